// File: rtl/cpu_mem_arbiter.sv
`default_nettype none
//------------------------------------------------------------------------------
// cpu_mem_arbiter : shares one memory port between fetch (IF) and load/store (LS),
// LS priority with a bounded LS streak. Optional perf counters: CPU_MEM_ARB_PERF_EN.
// Revision: 1.0
//------------------------------------------------------------------------------
module cpu_mem_arbiter #(
  parameter int AW            = 32,
  parameter int DW            = 32,
  parameter int MAX_LS_STREAK = 2,
  parameter int CNT_W         = 32
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                i_if_req,
  input  logic [AW-1:0]       i_if_addr,
  output logic                o_if_gnt,
  output logic                o_if_rvalid,
  output logic [DW-1:0]       o_if_rdata,
  input  logic                i_ls_req,
  input  logic [AW-1:0]       i_ls_addr,
  input  logic                i_ls_we,
  input  logic [DW/8-1:0]     i_ls_be,
  input  logic [DW-1:0]       i_ls_wdata,
  output logic                o_ls_gnt,
  output logic                o_ls_rvalid,
  output logic [DW-1:0]       o_ls_rdata,
  output logic                o_mem_req,
  input  logic                i_mem_gnt,
  output logic [AW-1:0]       o_mem_addr,
  output logic                o_mem_we,
  output logic [DW/8-1:0]     o_mem_be,
  output logic [DW-1:0]       o_mem_wdata,
  input  logic                i_mem_rvalid,
  input  logic [DW-1:0]       i_mem_rdata,
`ifdef CPU_MEM_ARB_PERF_EN
  output logic [CNT_W-1:0]    o_if_grant_cnt,
  output logic [CNT_W-1:0]    o_ls_grant_cnt,
  output logic [CNT_W-1:0]    o_if_stall_cnt,
`endif
  output logic                o_busy
);

  localparam int c_BW = DW / 8;
  localparam int c_SW = (MAX_LS_STREAK > 0) ? $clog2(MAX_LS_STREAK + 1) : 1;
  localparam logic [c_SW-1:0] c_STREAK_MAX = c_SW'(MAX_LS_STREAK);

  typedef enum logic [1:0] {
    S_IDLE     = 2'd0,
    S_REQ      = 2'd1,
    S_WAIT_RSP = 2'd2
  } state_t;

  state_t          r_state;
  state_t          w_state_nxt;
  logic            r_owner_ls;
  logic [c_SW-1:0] r_streak;
  logic            w_if_win;
  logic            w_ls_win;
  logic            w_streak_full;

  assign w_streak_full = (r_streak == c_STREAK_MAX);

  // Grants are gated by rst_n so nothing is granted while reset is held.
  always_comb begin
    w_state_nxt = r_state;
    w_if_win    = 1'b0;
    w_ls_win    = 1'b0;
    o_mem_req   = 1'b0;
    o_if_rvalid = 1'b0;
    o_ls_rvalid = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (rst_n) begin
          if (i_ls_req && !(i_if_req && w_streak_full)) begin
            w_ls_win = 1'b1;
          end else if (i_if_req) begin
            w_if_win = 1'b1;
          end
          if (w_ls_win || w_if_win) begin
            w_state_nxt = S_REQ;
          end
        end
      end
      S_REQ: begin
        o_mem_req = 1'b1;
        if (i_mem_gnt) begin
          w_state_nxt = S_WAIT_RSP;
        end
      end
      S_WAIT_RSP: begin
        if (i_mem_rvalid) begin
          o_ls_rvalid = r_owner_ls;
          o_if_rvalid = !r_owner_ls;
          w_state_nxt = S_IDLE;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  assign o_if_gnt   = w_if_win;
  assign o_ls_gnt   = w_ls_win;
  assign o_busy     = (r_state != S_IDLE);
  assign o_if_rdata = i_mem_rdata;
  assign o_ls_rdata = i_mem_rdata;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_owner_ls  <= 1'b0;
      o_mem_addr  <= '0;
      o_mem_we    <= 1'b0;
      o_mem_be    <= '0;
      o_mem_wdata <= '0;
    end else if (w_ls_win) begin
      r_owner_ls  <= 1'b1;
      o_mem_addr  <= i_ls_addr;
      o_mem_we    <= i_ls_we;
      o_mem_be    <= i_ls_be;
      o_mem_wdata <= i_ls_wdata;
    end else if (w_if_win) begin
      r_owner_ls  <= 1'b0;
      o_mem_addr  <= i_if_addr;
      o_mem_we    <= 1'b0;
      o_mem_be    <= {c_BW{1'b1}};
      o_mem_wdata <= '0;
    end
  end

  // Streak only grows while IF is actually being passed over.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_streak <= '0;
    end else if (w_ls_win) begin
      if (!i_if_req) begin
        r_streak <= '0;
      end else if (!w_streak_full) begin
        r_streak <= r_streak + c_SW'(1);
      end
    end else if (w_if_win) begin
      r_streak <= '0;
    end
  end

`ifdef CPU_MEM_ARB_PERF_EN
  logic [CNT_W-1:0] r_if_grant_cnt;
  logic [CNT_W-1:0] r_ls_grant_cnt;
  logic [CNT_W-1:0] r_if_stall_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_if_grant_cnt <= '0;
      r_ls_grant_cnt <= '0;
      r_if_stall_cnt <= '0;
    end else begin
      if (w_if_win) begin
        r_if_grant_cnt <= r_if_grant_cnt + CNT_W'(1);
      end
      if (w_ls_win) begin
        r_ls_grant_cnt <= r_ls_grant_cnt + CNT_W'(1);
      end
      if (i_if_req && !w_if_win) begin
        r_if_stall_cnt <= r_if_stall_cnt + CNT_W'(1);
      end
    end
  end

  assign o_if_grant_cnt = r_if_grant_cnt;
  assign o_ls_grant_cnt = r_ls_grant_cnt;
  assign o_if_stall_cnt = r_if_stall_cnt;
`endif

endmodule

`default_nettype wire

// File: doc/cpu_mem_arbiter.md
Name: cpu_mem_arbiter

Overview:
- Shares one single-ported memory interface between the instruction-fetch requester (IF, read-only) and the load/store requester (LS, read/write).
- Sits between the fetch/LSU logic and the unified memory under cpu_top.
- Allows one outstanding transaction at a time.
- LS has priority; a bounded-streak rule guarantees fetch progress.

Parameters:
AW, 32, address width
DW, 32, data width (multiple of 8)
MAX_LS_STREAK, 2, consecutive LS grants allowed while IF is waiting before IF is forced to win; 0 = IF always wins a tie
CNT_W, 32, perf counter width (only with CPU_MEM_ARB_PERF_EN)

Ports:
clk  in  1  clock
rst_n  in  1  async active-low reset
i_if_req  in  1  fetch request; held with addr until o_if_gnt
i_if_addr  in  AW  fetch address
o_if_gnt  out  1  fetch request accepted (1-cycle pulse)
o_if_rvalid  out  1  fetch response valid
o_if_rdata  out  DW  fetch read data
i_ls_req  in  1  LS request; held with addr/we/be/wdata until o_ls_gnt
i_ls_addr  in  AW  LS address
i_ls_we  in  1  1 = write
i_ls_be  in  DW/8  byte enables
i_ls_wdata  in  DW  write data
o_ls_gnt  out  1  LS request accepted (1-cycle pulse)
o_ls_rvalid  out  1  LS response valid (read data or write ack)
o_ls_rdata  out  DW  LS read data
o_mem_req  out  1  memory request
i_mem_gnt  in  1  memory accepted request
o_mem_addr  out  AW  registered address
o_mem_we  out  1  registered write enable
o_mem_be  out  DW/8  registered byte enables
o_mem_wdata  out  DW  registered write data
i_mem_rvalid  in  1  memory response; exactly one per accepted request, reads and writes alike
i_mem_rdata  in  DW  memory read data
o_busy  out  1  arbiter not in IDLE

Behaviour:
- Clock and reset: one clock `clk`. Reset `rst_n` is asynchronous and active-low.
- Reset: FSM goes to IDLE. All o_mem_*, o_*_gnt, o_*_rvalid, o_busy and owner are 0. LS streak counter is 0.
- FSM states: IDLE, REQ, WAIT_RSP.
- IDLE, arbitration (combinational):
  - Only one requester: that requester wins.
  - Both requesting: LS wins unless streak == MAX_LS_STREAK, in which case IF wins.
  - Winner's o_x_gnt = 1 in the same cycle.
  - At the clock edge: capture owner, addr, we, be and wdata into the o_mem_* registers, then go to REQ.
  - IF captures always set we=0 and be=all-ones.
- REQ: o_mem_req = 1; o_mem_* held stable.
  - i_mem_gnt = 1 → WAIT_RSP.
  - i_mem_gnt = 0 → remain in REQ.
- WAIT_RSP: o_mem_req = 0.
  - i_mem_rvalid = 1 → o_<owner>_rvalid = 1 in the same cycle (combinational), then go to IDLE.
  - i_mem_rvalid is legal no earlier than the cycle after i_mem_gnt.
- Read data: o_if_rdata and o_ls_rdata are both driven directly from i_mem_rdata. Consumers must qualify with their own rvalid.
- Streak counter update, on each LS grant:
  - If i_if_req was 1: increment, saturating at MAX_LS_STREAK.
  - Otherwise: clear to 0.
  - Also cleared on every IF grant.
- No grants outside IDLE. A request arriving in REQ or WAIT_RSP waits.
- Minimum latency: request in cycle N (IDLE), gnt in N, o_mem_req in N+1, mem gnt in N+1, rvalid in N+2. Best-case throughput is one transaction per 3 cycles.
- i_mem_rvalid in IDLE or REQ: ignored, no rvalid forwarded.
- Requester dropping req before gnt: legal; arbitration re-evaluates every IDLE cycle.
- Reset mid-transaction: in-flight transaction is abandoned and its response is never forwarded. The memory side must be reset with the same rst_n.

Optional Feature:
Macro: CPU_MEM_ARB_PERF_EN.
- Defined: extra outputs o_if_grant_cnt[CNT_W], o_ls_grant_cnt[CNT_W] and o_if_stall_cnt[CNT_W].
  - Grant counters increment on each o_if_gnt / o_ls_gnt.
  - Stall counter increments each cycle i_if_req = 1 and o_if_gnt = 0.
  - All counters wrap modulo 2^CNT_W and reset to 0.
- Not defined: these ports and counters do not exist; all other behaviour is identical.

Test Plan:
- IF read only, addr 0x100, memory gnt in 1st REQ cycle, rvalid 1 cycle later with 0xDEADBEEF → o_if_gnt in cycle 0, o_mem_req in cycle 1, o_if_rvalid with rdata 0xDEADBEEF in cycle 2, o_ls_rvalid stays 0.
- LS write addr 0x200, be 4'b0011, wdata 0x12345678; memory holds gnt low 3 cycles → o_mem_req/addr/be/wdata stable for 4 cycles; one o_ls_rvalid after the ack; o_mem_we = 1.
- IF and LS requesting continuously, MAX_LS_STREAK = 2 → grant order LS, LS, IF, LS, LS, IF…
- Same with MAX_LS_STREAK = 0 → IF wins every tie.
- Async reset asserted in WAIT_RSP, then i_mem_rvalid pulsed after release → all outputs 0 during reset; FSM in IDLE; no o_*_rvalid forwarded.
- With CPU_MEM_ARB_PERF_EN: 3 IF + 5 LS transactions under contention → o_if_grant_cnt = 3, o_ls_grant_cnt = 5, o_if_stall_cnt equal to the counted IF wait cycles.
